// File: rtl/pim_bus_arbiter.sv
// Round-robin arbiter sharing the PIM memory port between the CPU and the SPI bridge.
// Optional SPI burst lock is compiled in with `define PIM_ARB_LOCK_EN.
module pim_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_gnt,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    input  logic              i_spi_req,
    input  logic              i_spi_we,
    input  logic [ADDR_W-1:0] i_spi_addr,
    input  logic [DATA_W-1:0] i_spi_wdata,
`ifdef PIM_ARB_LOCK_EN
    input  logic              i_spi_lock,
`endif
    output logic              o_spi_gnt,
    output logic              o_spi_rvalid,
    output logic [DATA_W-1:0] o_spi_rdata,
    output logic              o_pim_en,
    output logic              o_pim_we,
    output logic [ADDR_W-1:0] o_pim_addr,
    output logic [DATA_W-1:0] o_pim_wr_data,
    input  logic [DATA_W-1:0] i_pim_rd_data
);

    typedef enum logic {
        SrcCpu = 1'b0,
        SrcSpi = 1'b1
    } src_e;

    src_e              last_grant_q;
    logic [RD_LAT:0]   tag_vld_q;
    logic [RD_LAT:0]   tag_src_q;
    logic              lock_block;
    logic              rd_push;
    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              cpu_hit;
    logic              spi_hit;

`ifdef PIM_ARB_LOCK_EN
    // Reset parks last_grant on SPI, so the lock also needs a real SPI win first.
    logic spi_won_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            spi_won_q <= 1'b0;
        end else if (o_spi_gnt) begin
            spi_won_q <= 1'b1;
        end
    end

    assign lock_block = i_spi_lock && spi_won_q && (last_grant_q == SrcSpi);
`else
    assign lock_block = 1'b0;
`endif

    always_comb begin
        o_cpu_gnt = 1'b0;
        o_spi_gnt = 1'b0;
        if (!i_rst) begin
            o_cpu_gnt = i_cpu_req && !lock_block && (!i_spi_req || last_grant_q == SrcSpi);
            o_spi_gnt = i_spi_req && !o_cpu_gnt;
        end
    end

    always_comb begin
        any_gnt   = o_cpu_gnt || o_spi_gnt;
        rd_push   = (o_cpu_gnt && !i_cpu_we) || (o_spi_gnt && !i_spi_we);
        sel_we    = o_spi_gnt ? i_spi_we    : i_cpu_we;
        sel_addr  = o_spi_gnt ? i_spi_addr  : i_cpu_addr;
        sel_wdata = o_spi_gnt ? i_spi_wdata : i_cpu_wdata;
        cpu_hit   = tag_vld_q[RD_LAT] && (tag_src_q[RD_LAT] == SrcCpu);
        spi_hit   = tag_vld_q[RD_LAT] && (tag_src_q[RD_LAT] == SrcSpi);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_grant_q  <= SrcSpi;
            o_pim_en      <= 1'b0;
            o_pim_we      <= 1'b0;
            o_pim_addr    <= '0;
            o_pim_wr_data <= '0;
        end else begin
            o_pim_en <= any_gnt;
            o_pim_we <= any_gnt && sel_we;
            if (any_gnt) begin
                last_grant_q  <= o_spi_gnt ? SrcSpi : SrcCpu;
                o_pim_addr    <= sel_addr;
                o_pim_wr_data <= sel_wdata;
            end
        end
    end

    // Stage k holds the tag of the command that has been on the PIM port for k cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tag_vld_q <= '0;
            tag_src_q <= '0;
        end else begin
            tag_vld_q <= {tag_vld_q[RD_LAT-1:0], rd_push};
            tag_src_q <= {tag_src_q[RD_LAT-1:0], o_spi_gnt};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_cpu_rvalid <= 1'b0;
            o_spi_rvalid <= 1'b0;
            o_cpu_rdata  <= '0;
            o_spi_rdata  <= '0;
        end else begin
            o_cpu_rvalid <= cpu_hit;
            o_spi_rvalid <= spi_hit;
            if (cpu_hit) begin
                o_cpu_rdata <= i_pim_rd_data;
            end
            if (spi_hit) begin
                o_spi_rdata <= i_pim_rd_data;
            end
        end
    end

endmodule
